fullxor_sched: RTL and testbench



---
 rtl/fullxor_sched.sv | 158 +++++++++++++++
 tb/tb_fullxor_sched.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fullxor_sched.sv
// fullxor_sched: round-robin front end for one shared FullXOR share-recombination
// pipeline. Each accepted masked operand is fused with one fresh randomness word,
// issued into the pipeline, and its requester ID is tracked in lockstep so that the
// unmasked result can be returned with the ID in a valid/ready output register.
//
// Handshakes (all single-clock, strict valid/ready):
//   - requester r: transfer when i_req_vld[r] & o_req_rdy[r]; the requester holds
//     i_req_vld/i_req_x stable until it sees o_req_rdy[r].
//   - randomness:  a word is consumed when i_rnd_vld & o_rnd_rdy; o_rnd_rdy is
//     only raised on an issue, so every word feeds exactly one operation.
//   - response:    transfer when o_rsp_vld & i_rsp_rdy; o_rsp_* hold while
//     o_rsp_vld & ~i_rsp_rdy.
module fullxor_sched #(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 3,
  parameter int RANDNUM  = 2,
  parameter int LAYERS   = 2,
  parameter int N_REQ    = 2,
  parameter int ID_W     = 1,
  parameter int CNT_W    = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [N_REQ-1:0]                     i_req_vld,
  input  logic [N_REQ*K_WIDTH*N_SHARES-1:0]    i_req_x,
  output logic [N_REQ-1:0]                     o_req_rdy,
  input  logic                                 i_rnd_vld,
  input  logic [K_WIDTH*RANDNUM-1:0]           i_rnd,
  output logic                                 o_rnd_rdy,
  output logic [K_WIDTH*N_SHARES-1:0]          o_dp_x,
  output logic [K_WIDTH*RANDNUM-1:0]           o_dp_n,
  output logic                                 o_dp_dvld,
  output logic                                 o_dp_rvld,
  input  logic [K_WIDTH-1:0]                   i_dp_z,
  input  logic                                 i_dp_dvld,
  output logic                                 o_rsp_vld,
  output logic [K_WIDTH-1:0]                   o_rsp_z,
  output logic [ID_W-1:0]                      o_rsp_id,
  input  logic                                 i_rsp_rdy,
  output logic [CNT_W-1:0]                     o_starve_cnt
);

  localparam int XW = K_WIDTH * N_SHARES;

  logic                   w_adv;
  logic                   w_any;
  logic                   w_issue;
  logic                   w_starve;
  logic                   w_found;
  logic [ID_W-1:0]        w_grant;
  logic [ID_W-1:0]        w_ptr_nxt;

  logic [ID_W-1:0]        r_ptr;
  logic [ID_W-1:0]        r_id_pipe [LAYERS];
  logic                   r_rsp_vld;
  logic [K_WIDTH-1:0]     r_rsp_z;
  logic [ID_W-1:0]        r_rsp_id;
  logic [CNT_W-1:0]       r_starve;

  // The whole pipeline advances whenever the output register can take a result.
  assign w_adv    = ~r_rsp_vld | i_rsp_rdy;
  assign w_any    = |i_req_vld;
  // Holding rst_ni in the issue term keeps every strobe low while in reset.
  assign w_issue  = rst_ni & w_adv & w_any & i_rnd_vld;
  assign w_starve = w_adv & w_any & ~i_rnd_vld;

  // Round-robin search: first scan from the pointer up to the top, then wrap to 0.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && i_req_vld[i] && (i >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_grant = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && i_req_vld[i]) begin
        w_found = 1'b1;
        w_grant = ID_W'(i);
      end
    end
  end

  // Pointer moves one past the granted requester, wrapping at N_REQ.
  assign w_ptr_nxt = (w_grant == ID_W'(N_REQ - 1)) ? '0 : w_grant + 1'b1;

  // One-hot accept and operand mux for the granted requester.
  always_comb begin
    o_req_rdy = '0;
    o_dp_x    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        o_req_rdy[i] = w_issue;
        o_dp_x       = i_req_x[i*XW +: XW];
      end
    end
  end

  assign o_dp_n       = i_rnd;
  assign o_dp_dvld    = w_issue;
  assign o_rnd_rdy    = w_issue;
  assign o_dp_rvld    = w_adv;
  assign o_rsp_vld    = r_rsp_vld;
  assign o_rsp_z      = r_rsp_z;
  assign o_rsp_id     = r_rsp_id;
  assign o_starve_cnt = r_starve;

  // Round-robin pointer register, updated only when an operation is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // ID shift register mirroring the datapath depth; frozen whenever the datapath is.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAYERS; i++) begin
        r_id_pipe[i] <= '0;
      end
    end else if (w_adv) begin
      if (w_issue) begin
        r_id_pipe[0] <= w_grant;
      end
      for (int i = 1; i < LAYERS; i++) begin
        r_id_pipe[i] <= r_id_pipe[i-1];
      end
    end
  end

  // Output register: a new result takes priority so drain+load gives no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_vld <= 1'b0;
      r_rsp_z   <= '0;
      r_rsp_id  <= '0;
    end else if (w_adv && i_dp_dvld) begin
      r_rsp_vld <= 1'b1;
      r_rsp_z   <= i_dp_z;
      r_rsp_id  <= r_id_pipe[LAYERS-1];
    end else if (i_rsp_rdy) begin
      r_rsp_vld <= 1'b0;
    end
  end

  // Saturating count of cycles where work was waiting only on randomness.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve <= '0;
    end else if (w_starve && (r_starve != {CNT_W{1'b1}})) begin
      r_starve <= r_starve + 1'b1;
    end
  end

endmodule

// File: tb/tb_fullxor_sched.sv
// Bench for fullxor_sched: a behavioural FullXOR datapath, a cycle reference model
// of arbitration/occupancy/starvation, a response scoreboard, directed scenarios and
// randomized traffic. A second small instance covers N_REQ=3 and CNT_W=4.
module tb_fullxor_sched;

  localparam int KW = 32;
  localparam int NS = 3;
  localparam int RN = 2;
  localparam int LY = 2;
  localparam int NR = 2;
  localparam int IW = 1;
  localparam int CW = 16;
  localparam int XW = KW * NS;
  localparam int NW = KW * RN;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic [NR-1:0]    req_vld;
  logic [NR*XW-1:0] req_x;
  logic [NR-1:0]    req_rdy;
  logic             rnd_vld;
  logic [NW-1:0]    rnd;
  logic             rnd_rdy;
  logic [XW-1:0]    dp_x;
  logic [NW-1:0]    dp_n;
  logic             dp_dvld;
  logic             dp_rvld;
  logic [KW-1:0]    dp_z;
  logic             dp_zvld;
  logic             rsp_vld;
  logic [KW-1:0]    rsp_z;
  logic [IW-1:0]    rsp_id;
  logic             rsp_rdy;
  logic [CW-1:0]    starve;

  fullxor_sched #(
    .K_WIDTH(KW), .N_SHARES(NS), .RANDNUM(RN), .LAYERS(LY),
    .N_REQ(NR), .ID_W(IW), .CNT_W(CW)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_req_vld(req_vld), .i_req_x(req_x), .o_req_rdy(req_rdy),
    .i_rnd_vld(rnd_vld), .i_rnd(rnd), .o_rnd_rdy(rnd_rdy),
    .o_dp_x(dp_x), .o_dp_n(dp_n), .o_dp_dvld(dp_dvld), .o_dp_rvld(dp_rvld),
    .i_dp_z(dp_z), .i_dp_dvld(dp_zvld),
    .o_rsp_vld(rsp_vld), .o_rsp_z(rsp_z), .o_rsp_id(rsp_id), .i_rsp_rdy(rsp_rdy),
    .o_starve_cnt(starve)
  );

  // ---------------- second DUT: 3 requesters, 4-bit counter ----------------
  logic [2:0]      b_req_vld;
  logic [3*XW-1:0] b_req_x;
  logic [2:0]      b_req_rdy;
  logic            b_rnd_vld;
  logic [NW-1:0]   b_rnd;
  logic            b_rnd_rdy;
  logic [XW-1:0]   b_dp_x;
  logic [NW-1:0]   b_dp_n;
  logic            b_dp_dvld;
  logic            b_dp_rvld;
  logic [KW-1:0]   b_dp_z;
  logic            b_dp_zvld;
  logic            b_rsp_vld;
  logic [KW-1:0]   b_rsp_z;
  logic [1:0]      b_rsp_id;
  logic            b_rsp_rdy;
  logic [3:0]      b_starve;

  fullxor_sched #(
    .K_WIDTH(KW), .N_SHARES(NS), .RANDNUM(RN), .LAYERS(LY),
    .N_REQ(3), .ID_W(2), .CNT_W(4)
  ) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .i_req_vld(b_req_vld), .i_req_x(b_req_x), .o_req_rdy(b_req_rdy),
    .i_rnd_vld(b_rnd_vld), .i_rnd(b_rnd), .o_rnd_rdy(b_rnd_rdy),
    .o_dp_x(b_dp_x), .o_dp_n(b_dp_n), .o_dp_dvld(b_dp_dvld), .o_dp_rvld(b_dp_rvld),
    .i_dp_z(b_dp_z), .i_dp_dvld(b_dp_zvld),
    .o_rsp_vld(b_rsp_vld), .o_rsp_z(b_rsp_z), .o_rsp_id(b_rsp_id), .i_rsp_rdy(b_rsp_rdy),
    .o_starve_cnt(b_starve)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [IW+KW-1:0] exp_q[$];
  int grant_log[$];
  logic [NR-1:0] seen_rdy;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [KW-1:0] xor_shares(input logic [XW-1:0] x);
    logic [KW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NS; i++) acc = acc ^ x[i*KW +: KW];
    return acc;
  endfunction

  // Mask refresh with the randomness (each word hits two shares) then recombine.
  function automatic logic [KW-1:0] refresh_combine(input logic [XW-1:0] x, input logic [NW-1:0] n);
    logic [KW-1:0] s [NS];
    logic [KW-1:0] acc;
    for (int i = 0; i < NS; i++) s[i] = x[i*KW +: KW];
    for (int i = 0; i < NS - 1; i++) begin
      s[i]   = s[i]   ^ n[(i % RN)*KW +: KW];
      s[i+1] = s[i+1] ^ n[(i % RN)*KW +: KW];
    end
    acc = '0;
    for (int i = 0; i < NS; i++) acc = acc ^ s[i];
    return acc;
  endfunction

  // ---------------- behavioural datapath (LY stages, global advance) ----------------
  logic [KW-1:0] pz [LY];
  logic          pv [LY];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LY; i++) begin
        pv[i] <= 1'b0;
        pz[i] <= '0;
      end
    end else if (dp_rvld) begin
      pv[0] <= dp_dvld;
      pz[0] <= refresh_combine(dp_x, dp_n);
      for (int i = 1; i < LY; i++) begin
        pv[i] <= pv[i-1];
        pz[i] <= pz[i-1];
      end
    end
  end
  assign dp_z    = pz[LY-1];
  assign dp_zvld = pv[LY-1];

  // ---------------- reference model (checked mid-cycle) ----------------
  int   m_ptr;
  logic m_rsp_vld;
  int   m_starve;
  always @(negedge clk) begin
    int   g;
    logic m_adv;
    logic m_issue;
    logic [NR-1:0] m_onehot;
    if (!rst_n) begin
      m_ptr = 0;
      m_rsp_vld = 1'b0;
      m_starve = 0;
      exp_q.delete();
      seen_rdy = '0;
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_rsp_z", rsp_z, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_rnd_rdy", rnd_rdy, 0);
      chk("rst_dp_dvld", dp_dvld, 0);
      chk("rst_starve", starve, 0);
    end else begin
      m_adv = !m_rsp_vld || rsp_rdy;
      g = -1;
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && req_vld[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      end
      m_issue = m_adv && (g >= 0) && rnd_vld;
      m_onehot = '0;
      if (m_issue) m_onehot[g] = 1'b1;
      chk("dp_rvld", dp_rvld, m_adv);
      chk("req_rdy", req_rdy, m_onehot);
      chk("rnd_rdy", rnd_rdy, m_issue);
      chk("dp_dvld", dp_dvld, m_issue);
      chk("rsp_vld", rsp_vld, m_rsp_vld);
      chk("starve_cnt", starve, m_starve);
      if (m_issue) begin
        chk("dp_x", dp_x, req_x[g*XW +: XW]);
        chk("dp_n", dp_n, rnd);
        exp_q.push_back({IW'(g), xor_shares(req_x[g*XW +: XW])});
      end
      for (int r = 0; r < NR; r++) if (req_rdy[r]) grant_log.push_back(r);
      seen_rdy = req_rdy;
      if (m_adv && (g >= 0) && !rnd_vld && m_starve < (1 << CW) - 1) m_starve++;
      if (m_adv && dp_zvld) m_rsp_vld = 1'b1;
      else if (rsp_rdy) m_rsp_vld = 1'b0;
      if (m_issue) m_ptr = (g + 1) % NR;
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  logic          prev_stall;
  logic [KW-1:0] held_z;
  logic [IW-1:0] held_id;
  always @(negedge clk) begin
    logic [IW+KW-1:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_vld", rsp_vld, 1);
        chk("stall_hold_z", rsp_z, held_z);
        chk("stall_hold_id", rsp_id, held_id);
      end
      if (rsp_vld && rsp_rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected actual z=%0h id=%0h required=none", rsp_z, rsp_id);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_z", rsp_z, e[KW-1:0]);
          chk("rsp_id", rsp_id, e[IW+KW-1:KW]);
        end
      end
      prev_stall = rsp_vld && !rsp_rdy;
      held_z = rsp_z;
      held_id = rsp_id;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic new_x(input int r);
    req_x[r*XW +: XW] = {$urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic idle();
    req_vld = '0;
    rnd_vld = 1'b0;
    rsp_rdy = 1'b1;
  endtask

  task automatic drain(input int max_cyc);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || rsp_vld) && c < max_cyc) begin
      cyc();
      c++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic rand_cycles(input int n, input int p_req, input int p_rnd, input int p_rdy);
    for (int c = 0; c < n; c++) begin
      cyc();
      for (int r = 0; r < NR; r++) begin
        if (!req_vld[r] || seen_rdy[r]) begin
          req_vld[r] = ($urandom_range(0, 99) < p_req);
          if (req_vld[r]) new_x(r);
        end
      end
      rnd_vld = ($urandom_range(0, 99) < p_rnd);
      rnd = {$urandom, $urandom};
      rsp_rdy = ($urandom_range(0, 99) < p_rdy);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    req_vld = '0; req_x = '0; rnd_vld = 1'b0; rnd = '0; rsp_rdy = 1'b1;
    b_req_vld = '0; b_req_x = '0; b_rnd_vld = 1'b0; b_rnd = '0; b_rsp_rdy = 1'b1;
    b_dp_z = '0; b_dp_zvld = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;

    // Single operation with known vector and latency.
    cyc();
    req_vld = 2'b01;
    req_x[XW-1:0] = {32'hA5A5A5A5, 32'h0F0F0F0F, 32'h12345678};
    rnd = {32'h22222222, 32'h11111111};
    rnd_vld = 1'b1;
    @(negedge clk);
    chk("single_issue", req_rdy, 2'b01);
    chk("single_rnd_rdy", rnd_rdy, 1);
    cyc();
    idle();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("single_latency_vld", rsp_vld, (c == 3));
      chk("single_rnd_once", rnd_rdy, 0);
    end
    chk("single_z", rsp_z, 32'hB89EFCD2);
    chk("single_id", rsp_id, 0);
    drain(10);

    // Round robin with both requesters continuously valid.
    do_reset();
    grant_log.delete();
    new_x(0); new_x(1);
    req_vld = 2'b11; rnd_vld = 1'b1; rsp_rdy = 1'b1;
    for (int c = 0; c < 20 && grant_log.size() < 6; c++) begin
      @(negedge clk);
      cyc();
      rnd = {$urandom, $urandom};
      for (int r = 0; r < NR; r++) if (seen_rdy[r]) new_x(r);
    end
    idle();
    chk("rr_issue_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % 2);
    drain(20);

    // Randomness starvation.
    do_reset();
    req_vld = 2'b01; new_x(0); rnd_vld = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("starve_no_issue", dp_dvld, 0);
    end
    cyc();
    rnd_vld = 1'b1; rnd = {$urandom, $urandom};
    @(negedge clk);
    chk("starve_cnt5", starve, 5);
    chk("starve_release", req_rdy, 2'b01);
    cyc();
    idle();
    drain(10);

    // Backpressure: stream, stall 3 cycles once a response shows, then finish.
    grant_log.delete();
    req_vld = 2'b01; new_x(0); rnd_vld = 1'b1; rsp_rdy = 1'b1;
    for (int c = 0; c < 20 && !rsp_vld; c++) begin
      @(negedge clk);
      if (!rsp_vld) begin
        cyc();
        if (seen_rdy[0]) new_x(0);
        rnd = {$urandom, $urandom};
      end
    end
    chk("bp_rsp_seen", rsp_vld, 1);
    cyc();
    if (seen_rdy[0]) new_x(0);
    rsp_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_rvld_low", dp_rvld, 0);
      chk("bp_no_accept", req_rdy, 0);
    end
    cyc();
    rsp_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cyc();
      if (seen_rdy[0]) break;
    end
    idle();
    chk("bp_ops_streamed", (grant_log.size() >= 4), 1);
    drain(20);

    // Reset with two operations in flight.
    grant_log.delete();
    new_x(0); new_x(1);
    req_vld = 2'b11; rnd_vld = 1'b1;
    for (int c = 0; c < 10 && grant_log.size() < 2; c++) begin
      @(negedge clk);
      cyc();
      for (int r = 0; r < NR; r++) if (seen_rdy[r]) req_vld[r] = 1'b0;
    end
    idle();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rst_flush_no_rsp", rsp_vld, 0);
    end
    chk("rst_flush_starve", starve, 0);
    cyc();
    new_x(0); new_x(1);
    req_vld = 2'b11; rnd_vld = 1'b1;
    @(negedge clk);
    chk("rst_flush_ptr0", req_rdy, 2'b01);
    cyc();
    idle();
    drain(10);

    // Randomized traffic.
    rand_cycles(400, 70, 75, 70);
    rand_cycles(200, 95, 100, 100);
    rand_cycles(150, 60, 40, 30);
    cyc();
    idle();
    drain(30);

    // Three-requester instance: counter saturation and lone-top-requester wrap.
    cyc();
    b_req_vld = 3'b001; b_rnd_vld = 1'b0;
    repeat (20) @(negedge clk);
    chk("b_starve_sat", b_starve, 15);
    cyc();
    b_req_vld = 3'b100; b_rnd_vld = 1'b1;
    @(negedge clk);
    chk("b_req2_first", b_req_rdy, 3'b100);
    cyc();
    @(negedge clk);
    chk("b_req2_second", b_req_rdy, 3'b100);
    chk("b_starve_hold", b_starve, 15);
    cyc();
    b_req_vld = 3'b111;
    @(negedge clk);
    chk("b_ptr_wrapped", b_req_rdy, 3'b001);
    cyc();
    b_req_vld = 3'b110;
    @(negedge clk);
    chk("b_next_grant", b_req_rdy, 3'b010);
    cyc();
    b_req_vld = '0; b_rnd_vld = 1'b0;
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
